// File: rtl/pwm_pkg.sv
// Shared constants for the PWM driver family: channel names of the classic
// RGB arrangement and the default prescaler terminal count.
package pwm_pkg;

  localparam int CH_RED   = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_BLUE  = 2;

  localparam int DEFAULT_FINAL_VALUE = 195;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (target written any time, active
// committed at period boundaries), optional one-step-per-period fade.
module pwm_channel #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [R-1:0] cnt,
  input  logic         boundary,
  input  logic         load,
  input  logic [R:0]   load_duty,
  input  logic         ramp_en,
  output logic         pwm_out,
  output logic         ramp_busy
);

  logic [R:0] target;
  logic [R:0] active;

  // active is updated from the pre-edge target, so a write landing on the
  // boundary edge waits for the following boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      target  <= '0;
      active  <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (load) begin
        target <= load_duty;
      end
      if (boundary) begin
        if (!ramp_en) begin
          active <= target;
        end else if (active < target) begin
          active <= active + 1'b1;
        end else if (active > target) begin
          active <= active - 1'b1;
        end
      end
      pwm_out <= enable && ({1'b0, cnt} < active);
    end
  end

  assign ramp_busy = (active != target);

endmodule

// File: rtl/multi_pwm_driver.sv
// N-channel PWM driver: shared prescaler and period counter, write decode with
// saturation, and a registered period_start pulse aligned with cnt==0.
module multi_pwm_driver
  import pwm_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int R           = 8,
  parameter int TIMER_BITS  = 8,
  parameter int FINAL_VALUE = DEFAULT_FINAL_VALUE,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [R:0]          wr_duty,
  input  logic [CHANNELS-1:0] ramp_en,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic [CHANNELS-1:0] ramp_busy
);

  localparam logic [R:0] FULL_DUTY = {1'b1, {R{1'b0}}};

  logic [TIMER_BITS-1:0] presc;
  logic [R-1:0]          cnt;
  logic                  tick;
  logic                  boundary;
  logic [R:0]            sat_duty;

  assign tick     = enable && (presc == TIMER_BITS'(FINAL_VALUE));
  assign boundary = tick && (cnt == '1);
  assign sat_duty = (wr_duty > FULL_DUTY) ? FULL_DUTY : wr_duty;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (enable) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // wr_en is a fire-and-forget strobe with no ready; an index matching no
  // channel simply selects nothing.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .R(R)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .cnt      (cnt),
      .boundary (boundary),
      .load     (wr_en && (wr_ch == CH_W'(i))),
      .load_duty(sat_duty),
      .ramp_en  (ramp_en[i]),
      .pwm_out  (pwm_out[i]),
      .ramp_busy(ramp_busy[i])
    );
  end

endmodule

// File: tb/tb_multi_pwm_driver.sv
// Bench for multi_pwm_driver (R=3, FINAL_VALUE=1, 3 channels): directed duty
// table, hand-written corner sequences and a randomized scoreboard run.
module tb_multi_pwm_driver;
  import pwm_pkg::*;

  localparam int NCH = 3;
  localparam int RR  = 3;
  localparam int FV  = 1;
  localparam int FULL = 8;

  logic           clk;
  logic           reset;
  logic           enable;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [RR:0]    wr_duty;
  logic [NCH-1:0] ramp_en;
  logic [NCH-1:0] pwm_out;
  logic           period_start;
  logic [NCH-1:0] ramp_busy;

  multi_pwm_driver #(
    .CHANNELS(NCH), .R(RR), .TIMER_BITS(8), .FINAL_VALUE(FV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .ramp_en(ramp_en), .pwm_out(pwm_out),
    .period_start(period_start), .ramp_busy(ramp_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Reference model: counts enabled clocks and derives cnt/boundary by
  // arithmetic; keeps target/active duties as plain integers.
  logic [6:0] exp_q[$];
  int m_en_clk;
  int m_tgt[NCH];
  int m_act[NCH];
  int m_cnt;
  bit m_tick;
  bit m_bnd;
  logic [6:0] m_e;

  always @(posedge clk) begin
    m_e = '0;
    if (reset) begin
      m_en_clk = 0;
      for (int i = 0; i < NCH; i++) begin
        m_tgt[i] = 0;
        m_act[i] = 0;
      end
    end else begin
      m_cnt  = (m_en_clk / (FV + 1)) % FULL;
      m_tick = enable && ((m_en_clk % (FV + 1)) == FV);
      m_bnd  = m_tick && (m_cnt == FULL - 1);
      for (int i = 0; i < NCH; i++) m_e[4+i] = enable && (m_cnt < m_act[i]);
      if (m_bnd) begin
        for (int i = 0; i < NCH; i++) begin
          if (!ramp_en[i]) m_act[i] = m_tgt[i];
          else if (m_act[i] < m_tgt[i]) m_act[i] = m_act[i] + 1;
          else if (m_act[i] > m_tgt[i]) m_act[i] = m_act[i] - 1;
        end
      end
      if (wr_en && int'(wr_ch) < NCH) m_tgt[wr_ch] = (int'(wr_duty) > FULL) ? FULL : int'(wr_duty);
      if (enable) m_en_clk = (m_en_clk + 1) % ((FV + 1) * FULL);
      m_e[3] = m_bnd;
      for (int i = 0; i < NCH; i++) m_e[i] = (m_act[i] != m_tgt[i]);
    end
    exp_q.push_back(m_e);
  end

  // scoreboard
  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {25'd0, pwm_out, period_start, ramp_busy}, {25'd0, e});
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_duty = 4'(duty);
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!period_start && n < 40);
    check("period_start_seen", period_start, 1);
  endtask

  // Counts high clocks of each channel over one full period; starts and ends
  // on a period_start sample.
  task automatic count_period(output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    repeat (16) begin
      cyc();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
    end
  endtask

  typedef struct {
    int ch;
    int duty;
    int exp_hi;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int h[3];
    int hm;
    int bad;
    int n;

    vecs[0] = '{CH_RED,    3,  6};
    vecs[1] = '{CH_GREEN,  1,  2};
    vecs[2] = '{CH_BLUE,  15, 16};
    vecs[3] = '{CH_RED,    7, 14};
    vecs[4] = '{CH_GREEN,  8, 16};
    vecs[5] = '{CH_BLUE,   4,  8};
    vecs[6] = '{CH_GREEN,  0,  0};

    reset = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; ramp_en = '0;
    repeat (3) cyc();
    check("reset_pwm_out", pwm_out, 0);
    check("reset_period_start", period_start, 0);
    check("reset_ramp_busy", ramp_busy, 0);
    reset = 1'b0;

    // basic duties
    wr(CH_RED, 3);
    wr(CH_GREEN, 8);
    wr(CH_BLUE, 0);
    wait_ps();
    count_period(h[0], h[1], h[2]);
    check("basic_ch0_hi", h[0], 6);
    check("basic_ch1_hi", h[1], 16);
    check("basic_ch2_hi", h[2], 0);

    // duty table, each written early in a period
    for (int v = 0; v < 7; v++) begin
      wait_ps();
      cyc(); cyc();
      wr(vecs[v].ch, vecs[v].duty);
      wait_ps();
      count_period(h[0], h[1], h[2]);
      check("table_hi", h[vecs[v].ch], vecs[v].exp_hi);
    end

    // mid-period write: ch0 7 -> 5
    hm = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      hm += int'(pwm_out[0]);
      if (k == 4) begin wr_en = 1'b1; wr_ch = 2'(CH_RED); wr_duty = 4'd5; end
      if (k == 5) wr_en = 1'b0;
    end
    check("midwrite_old_period", hm, 14);
    check("midwrite_at_ps_old", pwm_out[0], 0);
    cyc();
    check("midwrite_first_new", pwm_out[0], 1);
    repeat (15) cyc();
    check("midwrite_ps_align", period_start, 1);

    // write in the exact boundary cycle: ch0 5 -> 1
    hm = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      hm += int'(pwm_out[0]);
      if (k == 15) begin wr_en = 1'b1; wr_ch = 2'(CH_RED); wr_duty = 4'd1; end
      if (k == 16) wr_en = 1'b0;
    end
    check("bndwrite_cur", hm, 10);
    count_period(h[0], h[1], h[2]);
    check("bndwrite_not_committed", h[0], 10);
    count_period(h[0], h[1], h[2]);
    check("bndwrite_committed", h[0], 2);

    // ramp ch1 0 -> 4
    ramp_en = 3'b010;
    cyc();
    wr(CH_GREEN, 4);
    wait_ps();
    check("ramp_busy_a1", ramp_busy[1], 1);
    count_period(h[0], h[1], h[2]);
    check("ramp_hi_1", h[1], 2);
    check("ramp_busy_a2", ramp_busy[1], 1);
    count_period(h[0], h[1], h[2]);
    check("ramp_hi_2", h[1], 4);
    check("ramp_busy_a3", ramp_busy[1], 1);
    count_period(h[0], h[1], h[2]);
    check("ramp_hi_3", h[1], 6);
    check("ramp_busy_a4", ramp_busy[1], 0);
    count_period(h[0], h[1], h[2]);
    check("ramp_hi_4", h[1], 8);

    // out-of-range channel write
    cyc(); cyc();
    wr(3, 2);
    wait_ps();
    count_period(h[0], h[1], h[2]);
    check("oor_ch0", h[0], 2);
    check("oor_ch1", h[1], 8);
    check("oor_ch2", h[2], 8);
    check("oor_busy", ramp_busy, 0);

    // enable low for 20 clocks mid-period
    repeat (5) cyc();
    enable = 1'b0;
    bad = 0;
    repeat (20) begin
      cyc();
      if (pwm_out != 0 || period_start) bad++;
    end
    check("disable_outputs_low", bad, 0);
    enable = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!period_start && n < 40);
    check("resume_latency", n, 11);

    // reset while ch1 ramps 4 -> 8
    wr(CH_GREEN, 8);
    wait_ps();
    cyc(); cyc();
    check("preramp_pwm1_high", pwm_out[1], 1);
    check("preramp_busy1", ramp_busy[1], 1);
    reset = 1'b1;
    cyc();
    check("midramp_reset_pwm", pwm_out, 0);
    check("midramp_reset_busy", ramp_busy, 0);
    check("midramp_reset_ps", period_start, 0);
    reset = 1'b0;

    // randomized run against the model
    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_ch  = 2'($urandom_range(0, 3));
      wr_duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) ramp_en = 3'($urandom_range(0, 7));
      cyc();
    end
    reset = 1'b0; wr_en = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_pwm_driver.md
# multi_pwm_driver

Parametrised N-channel PWM driver: the successor to the fixed three-channel RGB driver. One shared prescaler and period counter drive CHANNELS comparators. Each channel has a double-buffered duty register that commits only at a period boundary, so updates never glitch the output. An optional per-channel ramp mode fades the live duty toward its target by one step per PWM period. It sits between game/control logic and the board LED pins, generalising colour output to any LED count.

## Interface
- CHANNELS, 3: number of PWM outputs (1..16).
- R, 8: duty resolution; a PWM period is 2^R ticks; duty values are R+1 bits so 2^R encodes 100 %.
- TIMER_BITS, 8: prescaler counter width.
- FINAL_VALUE, 195: prescaler terminal count; one tick every FINAL_VALUE+1 clocks.
- Timing: one clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run; 0 = counters hold, all pwm_out forced 0.
- wr_en  in  1  write strobe for the target duty.
- wr_ch  in  $clog2(CHANNELS) (min 1)  channel index for the write.
- wr_duty  in  R+1  new target duty.
- ramp_en  in  CHANNELS  per-channel fade enable.
- pwm_out  out  CHANNELS  PWM outputs, registered.
- period_start  out  1  one-clock pulse on each commit edge.
- ramp_busy  out  CHANNELS  1 while that channel's live duty differs from its target.

## Operation
- Prescaler: counts 0..FINAL_VALUE while enable=1. tick=1 in the cycle where the count equals FINAL_VALUE; the count then wraps to 0.
- Period counter cnt (R bits) increments on tick and wraps from 2^R-1 to 0. A boundary is tick && cnt==2^R-1.
- Write: when wr_en=1 and wr_ch<CHANNELS, target[wr_ch] is loaded with min(wr_duty, 2^R). Out-of-range wr_ch is ignored.
- Commit at a boundary, per channel:
  - ramp_en=0: active ← target.
  - ramp_en=1: active moves one step toward target (+1 or −1). It is unchanged if already equal.
- Commit uses the target value held before that clock edge. A write in the same cycle as the boundary is applied at the next boundary.
- Compare: pwm_out[i] ← enable && (cnt < active[i]).
  - active=0 gives constant low.
  - active=2^R gives constant high.
- ramp_busy[i] = (active[i] != target[i]). It is combinational from registers.
- enable=0: prescaler, cnt, active and target all hold, and writes are still accepted. pwm_out and period_start are 0.

## Timing
- Reset values: prescaler=0, cnt=0, target=0, active=0, pwm_out=0, period_start=0, ramp_busy=0.
- Reset mid-period: all state clears on the next edge, with no partial-period completion.
- pwm_out lags cnt by one clock. A committed duty first appears in the pwm_out of the first cycle of the next period.
- PWM period: (FINAL_VALUE+1)·2^R clocks.
- Worst-case write-to-output latency with ramp off: one full period plus 1 clock.
- Full ramp 0→2^R takes 2^R periods.
- period_start is registered and asserts on the clock after the boundary edge, aligned with cnt=0.

## Structure
- Shared package/include (`pwm_pkg`) holds:
  - the channel index constants CH_RED=0, CH_GREEN=1, CH_BLUE=2;
  - the default FINAL_VALUE.
- One sub-module, `pwm_channel`: target/active registers, ramp step, comparator and output flop. It is instantiated CHANNELS times in a generate loop.
- The top level owns the prescaler, period counter, write decode and period_start.

## Test plan
Bench parameters for all scenarios: R=3, FINAL_VALUE=1, CHANNELS=3.
- Reset, then write ch0=3, ch1=8, ch2=0 with ramp off. After the next boundary, over one 16-clock period:
  - ch0 is high for 6 clocks;
  - ch1 is always high;
  - ch2 is always low.
- Write ch0=5 mid-period. The current period keeps the old duty; the new duty appears one clock after period_start.
- Write issued in the exact boundary cycle. Not committed at that boundary; committed at the following one.
- ramp_en[1]=1, target 0→4. active rises 1, 2, 3, 4 on successive boundaries. ramp_busy[1] deasserts when active reaches 4.
- wr_duty=15 on ch2 saturates to 8. Write to wr_ch=3 is ignored with no state change.
- enable=0 for 20 clocks mid-period:
  - all outputs are 0 and period_start stays 0;
  - after re-enable, cnt resumes from the held value.
- reset asserted mid-ramp: every output is 0 the next clock and all ramp_busy bits are 0.
